// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the instruction/data RAM arbiter.
// Response owner codes, grant codes and the fetch starvation limit.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_INSTR = 2'd1,
    RESP_DATA  = 2'd2
  } resp_e;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_INSTR = 2'd1,
    GNT_DATA  = 2'd2
  } grant_e;

  localparam int ARB_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational pick between fetch and data for one RAM slot.
// Data has priority unless fetch has lost STARVE_MAX times in a row.
module mem_arb_prio
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic       rst,
  input  logic       i_req,
  input  logic       d_req,
  input  resp_e      resp,
  input  logic [3:0] starve_cnt,
  output logic       i_elig,
  output logic       conflict,
  output logic       grant_i,
  output logic       grant_d
);

  logic d_elig;
  logic force_i;

  // The owner being acknowledged now must not be granted again.
  assign i_elig   = !rst && i_req && (resp != RESP_INSTR);
  assign d_elig   = !rst && d_req && (resp != RESP_DATA);
  assign conflict = i_elig && d_elig;
  assign force_i  = (starve_cnt == 4'(STARVE_MAX));
  assign grant_i  = i_elig && (!d_elig || force_i);
  assign grant_d  = d_elig && !grant_i;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one synchronous-read RAM between fetch and data ports.
// One access per cycle; responses return one cycle after the grant.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_rdy,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_rdy,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [15:0]         conflict_cnt
);

  resp_e      resp;
  logic       resp_wr;
  logic [3:0] starve_cnt;
  logic       i_elig;
  logic       conflict;
  logic       grant_i;
  logic       grant_d;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .rst       (rst),
    .i_req     (i_req),
    .d_req     (d_req),
    .resp      (resp),
    .starve_cnt(starve_cnt),
    .i_elig    (i_elig),
    .conflict  (conflict),
    .grant_i   (grant_i),
    .grant_d   (grant_d)
  );

  always_comb begin
    ram_en    = grant_i | grant_d;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant_d) begin
      ram_we    = d_we;
      ram_addr  = d_addr;
      ram_wdata = d_wdata;
    end else if (grant_i) begin
      ram_addr  = i_addr;
    end
  end

  // Held in reset, a pending response is dropped immediately.
  assign i_rdy   = !rst && (resp == RESP_INSTR);
  assign d_rdy   = !rst && (resp == RESP_DATA);
  assign i_rdata = i_rdy ? ram_rdata : '0;
  assign d_rdata = (d_rdy && !resp_wr) ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp         <= RESP_NONE;
      resp_wr      <= 1'b0;
      starve_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      unique case (1'b1)
        grant_i: resp <= RESP_INSTR;
        grant_d: resp <= RESP_DATA;
        default: resp <= RESP_NONE;
      endcase
      resp_wr <= grant_d && (|d_we);
      if (grant_i || !i_req)
        starve_cnt <= '0;
      else if (i_elig && (starve_cnt < 4'(STARVE_MAX)))
        starve_cnt <= starve_cnt + 4'd1;
      if (conflict && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a cycle-level reference model.
// A small RAM model answers the DUT's ram_* port.
module tb_mem_bus_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rdy;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rdy;
  logic [31:0] d_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [15:0] conflict_cnt;

  mem_bus_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_MAX(SM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_rdy       (i_rdy),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdy       (d_rdy),
    .d_rdata     (d_rdata),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Word-addressed RAM with byte enables and one-cycle read.
  logic [31:0] mem [logic [29:0]];
  logic [31:0] rw;
  always @(posedge clk) begin
    if (ram_en) begin
      rw = mem.exists(ram_addr[31:2]) ? mem[ram_addr[31:2]] : 32'h0;
      ram_rdata <= rw;
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) rw[8*b +: 8] = ram_wdata[8*b +: 8];
      mem[ram_addr[31:2]] = rw;
    end
  end

  // Model state: owner of last cycle's access (0 none, 1 fetch, 2 data).
  int m_own = 0, n_own = 0;
  bit m_wr = 0, n_wr = 0;
  int m_starve = 0, n_starve = 0;
  int m_conf = 0, n_conf = 0;
  bit chk_en = 0;
  bit conf_ld = 0;
  bit ie, de;
  int win;

  always @(negedge clk) begin
    ie  = !rst && i_req && (m_own != 1);
    de  = !rst && d_req && (m_own != 2);
    win = 0;
    if (ie && de) win = (m_starve == SM) ? 1 : 2;
    else if (ie) win = 1;
    else if (de) win = 2;
    if (chk_en) begin
      chk("m_ram_en", ram_en, win != 0);
      chk("m_ram_addr", ram_addr,
          win == 1 ? i_addr : (win == 2 ? d_addr : 32'h0));
      chk("m_ram_we", ram_we, win == 2 ? d_we : 4'h0);
      chk("m_ram_wdata", ram_wdata, win == 2 ? d_wdata : 32'h0);
      chk("m_i_rdy", i_rdy, !rst && m_own == 1);
      chk("m_i_rdata", i_rdata,
          (!rst && m_own == 1) ? ram_rdata : 32'h0);
      chk("m_d_rdy", d_rdy, !rst && m_own == 2);
      chk("m_d_rdata", d_rdata,
          (!rst && m_own == 2 && !m_wr) ? ram_rdata : 32'h0);
      chk("m_conflict_cnt", conflict_cnt, m_conf);
    end
    n_own = win;
    n_wr  = (win == 2) && (d_we != 0);
    if (win == 1 || !i_req) n_starve = 0;
    else if (ie) n_starve = (m_starve < SM) ? m_starve + 1 : SM;
    else n_starve = m_starve;
    n_conf = (ie && de && m_conf < 65535) ? m_conf + 1 : m_conf;
    if (rst) begin
      n_own = 0; n_wr = 0; n_starve = 0; n_conf = 0;
    end
  end

  always @(posedge clk) begin
    m_own    <= n_own;
    m_wr     <= n_wr;
    m_starve <= n_starve;
    m_conf   <= conf_ld ? 32'hFFFD : n_conf;
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = '0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  int waited;
  bit got;

  initial begin
    rst = 1;
    idle();
    mem[30'h10] = 32'hDEAD_BEEF;
    mem[30'h04] = 32'hAAAA_AAAA;
    mem[30'h40] = 32'h1111_2222;
    mem[30'h80] = 32'h0BAD_F00D;
    next_cyc();
    chk_en = 1;
    next_cyc();
    @(negedge clk);
    chk("rst_conflict", conflict_cnt, 16'h0);
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_rdy", {i_rdy, d_rdy}, 2'b00);

    // Lone fetch
    next_cyc();
    rst = 0; i_req = 1; i_addr = 32'h40;
    @(negedge clk);
    chk("lone_en", ram_en, 1'b1);
    chk("lone_addr", ram_addr, 32'h40);
    next_cyc();
    @(negedge clk);
    chk("lone_rdy", i_rdy, 1'b1);
    chk("lone_rdata", i_rdata, 32'hDEAD_BEEF);
    chk("lone_no_regrant", ram_en, 1'b0);
    next_cyc();
    @(negedge clk);
    chk("lone_regrant", ram_en, 1'b1);
    next_cyc();
    @(negedge clk);
    chk("lone_rdy2", i_rdy, 1'b1);
    next_cyc();
    i_req = 0;

    // Simultaneous requests
    i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h200;
    @(negedge clk);
    chk("sim_d_first", ram_addr, 32'h200);
    next_cyc();
    @(negedge clk);
    chk("sim_d_rdy", d_rdy, 1'b1);
    chk("sim_d_rdata", d_rdata, 32'h0BAD_F00D);
    chk("sim_i_next", ram_addr, 32'h100);
    next_cyc();
    d_req = 0;
    @(negedge clk);
    chk("sim_i_rdy", i_rdy, 1'b1);
    chk("sim_i_rdata", i_rdata, 32'h1111_2222);
    chk("sim_conflict", conflict_cnt, 16'd1);
    next_cyc();
    idle();

    // Data write, then read back
    d_req = 1; d_we = 4'b0011; d_addr = 32'h10; d_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("wr_we", ram_we, 4'b0011);
    chk("wr_wdata", ram_wdata, 32'h1234_5678);
    next_cyc();
    @(negedge clk);
    chk("wr_rdy", d_rdy, 1'b1);
    chk("wr_rdata0", d_rdata, 32'h0);
    next_cyc();
    d_we = 4'b0000; d_wdata = '0;
    next_cyc();
    d_req = 0;
    @(negedge clk);
    chk("wr_readback", d_rdata, 32'hAAAA_5678);
    next_cyc();
    idle();

    // Starvation bound with both ports requesting continuously
    i_req = 1; i_addr = 32'h300; d_req = 1; d_addr = 32'h400;
    waited = 0; got = 0;
    for (int k = 0; k < 7 && !got; k++) begin
      @(negedge clk);
      if (ram_en && ram_addr == 32'h300) got = 1;
      else begin
        waited++;
        next_cyc();
      end
    end
    chk("starve_grant", got, 1'b1);
    chk("starve_wait", waited <= SM + 1, 1'b1);
    next_cyc();
    i_req = 0;
    next_cyc();
    d_req = 0;
    next_cyc();
    idle();

    // Reset mid-access
    d_req = 1; d_addr = 32'h200;
    @(negedge clk);
    chk("rma_grant", ram_en, 1'b1);
    next_cyc();
    rst = 1; i_req = 1; i_addr = 32'h40;
    @(negedge clk);
    chk("rma_no_rdy", d_rdy, 1'b0);
    chk("rma_no_en", ram_en, 1'b0);
    next_cyc();
    rst = 0;
    idle();
    @(negedge clk);
    chk("rma_after_rdy", {i_rdy, d_rdy}, 2'b00);
    chk("rma_conflict", conflict_cnt, 16'h0);

    // Request dropped before rdy still completes
    next_cyc();
    i_req = 1; i_addr = 32'h40;
    next_cyc();
    i_req = 0;
    @(negedge clk);
    chk("drop_rdy", i_rdy, 1'b1);
    chk("drop_rdata", i_rdata, 32'hDEAD_BEEF);
    next_cyc();

    // Saturation, preloaded near the top
    chk_en = 0; conf_ld = 1;
    force dut.conflict_cnt = 16'hFFFD;
    next_cyc();
    release dut.conflict_cnt;
    conf_ld = 0; chk_en = 1;
    for (int k = 0; k < 4; k++) begin
      i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h200;
      next_cyc();
      idle();
      next_cyc();
    end
    @(negedge clk);
    chk("sat_hold", conflict_cnt, 16'hFFFF);
    next_cyc();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
